// File: rtl/fft_mdc_stage.sv
// fft_mdc_stage: radix-2 MDC FFT stage with a registered butterfly, down-lane twiddle multiply, round/saturate and a delay commutator.
// Define FFT_MDC_STAGE_SATCNT_EN to add the o_sat_count port counting clipped output components.
module fft_mdc_stage #(
    parameter int NBITS_IN    = 11,
    parameter int NBITS_COEFF = 11,
    parameter int NBF_COEFF   = 9,
    parameter int NBITS_OUT   = 12,
    parameter int DELAY       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    input  logic [2*NBITS_IN-1:0]      i_up,
    input  logic [2*NBITS_IN-1:0]      i_down,
    output logic [$clog2(2*DELAY)-1:0] coeff_addr,
    input  logic [2*NBITS_COEFF-1:0]   coeff_in,
    output logic                       o_valid,
    output logic [2*NBITS_OUT-1:0]     o_up,
    output logic [2*NBITS_OUT-1:0]     o_down,
    output logic                       o_sat
`ifdef FFT_MDC_STAGE_SATCNT_EN
    ,
    output logic [15:0]                o_sat_count
`endif
);

    localparam int BW    = NBITS_IN + 1;
    localparam int PW    = BW + NBITS_COEFF + 1;
    localparam int AW    = $clog2(2*DELAY);
    localparam int DW    = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int DEPTH = 1 << DW;
    localparam int EW    = 2*NBITS_OUT + 2;

    localparam logic signed [PW-1:0] SAT_MAX   = PW'((1 << (NBITS_OUT - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_MIN   = ~SAT_MAX;
    localparam logic signed [PW-1:0] ROUND     = PW'(1 << (NBF_COEFF - 1));
    localparam logic [AW:0]          FILL_LAST = (AW+1)'(DELAY + 1);

    typedef enum logic {
        ST_FILL,
        ST_RUN
    } state_t;

    state_t state;
    state_t state_next;
    logic   out_en;

    logic [AW:0]   fill_cnt;
    logic [AW-1:0] in_cnt;
    logic [AW-1:0] m_idx;
    logic          phase;
    logic [DW-1:0] ptr;

    logic signed [NBITS_IN-1:0]    up_re, up_im, dn_re, dn_im;
    logic signed [BW-1:0]          s1_ar, s1_ai, s1_br, s1_bi;
    logic signed [NBITS_COEFF-1:0] c_re, c_im;
    logic signed [PW-1:0]          p_re, p_im;
    logic [NBITS_OUT:0]            sat_ar, sat_ai, sat_lr, sat_li;

    // Entry layout: {clip_re, clip_im, re, im}
    logic [EW-1:0] s2_u, s2_l;
    logic [EW-1:0] dl_u [DEPTH];
    logic [EW-1:0] dl_l [DEPTH];
    logic [EW-1:0] l_del, u_del, sw_up, sw_dn;

    function automatic logic [NBITS_OUT:0] saturate(input logic signed [PW-1:0] v);
        logic [NBITS_OUT:0] r;
        if (v > SAT_MAX) begin
            r = {1'b1, SAT_MAX[NBITS_OUT-1:0]};
        end else if (v < SAT_MIN) begin
            r = {1'b1, SAT_MIN[NBITS_OUT-1:0]};
        end else begin
            r = {1'b0, v[NBITS_OUT-1:0]};
        end
        return r;
    endfunction

    assign up_re = i_up[2*NBITS_IN-1:NBITS_IN];
    assign up_im = i_up[NBITS_IN-1:0];
    assign dn_re = i_down[2*NBITS_IN-1:NBITS_IN];
    assign dn_im = i_down[NBITS_IN-1:0];
    assign c_re  = coeff_in[2*NBITS_COEFF-1:NBITS_COEFF];
    assign c_im  = coeff_in[NBITS_COEFF-1:0];

    // Index of the next accepted sample; the sample in S1 is one behind, the one in S2 two behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt <= '0;
        end else if (i_valid) begin
            in_cnt <= in_cnt + AW'(1);
        end
    end

    assign coeff_addr = in_cnt - AW'(1);
    assign m_idx      = in_cnt - AW'(2);
    assign phase      = m_idx[AW-1];
    assign ptr        = DW'(m_idx % DELAY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt <= '0;
        end else if (i_valid && (state == ST_FILL)) begin
            fill_cnt <= fill_cnt + (AW+1)'(1);
        end
    end

    // Accept DELAY+1 is the last one before the first pair leaves the commutator.
    always_comb begin
        state_next = state;
        if ((state == ST_FILL) && i_valid && (fill_cnt == FILL_LAST)) begin
            state_next = ST_RUN;
        end
    end

    always_comb begin
        out_en = 1'b0;
        if (state == ST_RUN) begin
            out_en = i_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_ar <= '0;
            s1_ai <= '0;
            s1_br <= '0;
            s1_bi <= '0;
        end else if (i_valid) begin
            s1_ar <= BW'(up_re) + BW'(dn_re);
            s1_ai <= BW'(up_im) + BW'(dn_im);
            s1_br <= BW'(up_re) - BW'(dn_re);
            s1_bi <= BW'(up_im) - BW'(dn_im);
        end
    end

    always_comb begin
        p_re   = PW'(s1_br) * PW'(c_re) - PW'(s1_bi) * PW'(c_im);
        p_im   = PW'(s1_br) * PW'(c_im) + PW'(s1_bi) * PW'(c_re);
        sat_lr = saturate((p_re + ROUND) >>> NBF_COEFF);
        sat_li = saturate((p_im + ROUND) >>> NBF_COEFF);
        sat_ar = saturate(PW'(s1_ar));
        sat_ai = saturate(PW'(s1_ai));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_u <= '0;
            s2_l <= '0;
        end else if (i_valid) begin
            s2_u <= {sat_ar[NBITS_OUT], sat_ai[NBITS_OUT], sat_ar[NBITS_OUT-1:0], sat_ai[NBITS_OUT-1:0]};
            s2_l <= {sat_lr[NBITS_OUT], sat_li[NBITS_OUT], sat_lr[NBITS_OUT-1:0], sat_li[NBITS_OUT-1:0]};
        end
    end

    // Both delay lines are circular buffers read before write, so a slot returns what was stored DELAY accepts ago.
    always_comb begin
        l_del = dl_l[ptr];
        u_del = dl_u[ptr];
        if (phase) begin
            sw_up = l_del;
            sw_dn = s2_u;
        end else begin
            sw_up = s2_u;
            sw_dn = l_del;
        end
    end

    always_ff @(posedge clk) begin
        if (i_valid) begin
            dl_l[ptr] <= s2_l;
            dl_u[ptr] <= sw_up;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_up    <= '0;
            o_down  <= '0;
            o_sat   <= 1'b0;
        end else begin
            o_valid <= out_en;
            if (out_en) begin
                o_up   <= u_del[2*NBITS_OUT-1:0];
                o_down <= sw_dn[2*NBITS_OUT-1:0];
                o_sat  <= |{u_del[EW-1:EW-2], sw_dn[EW-1:EW-2]};
            end
        end
    end

`ifdef FFT_MDC_STAGE_SATCNT_EN
    logic [2:0]  clip_cnt;
    logic [16:0] sat_sum;

    always_comb begin
        clip_cnt = 3'(u_del[EW-1]) + 3'(u_del[EW-2]) + 3'(sw_dn[EW-1]) + 3'(sw_dn[EW-2]);
        sat_sum  = {1'b0, o_sat_count} + 17'(clip_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_sat_count <= '0;
        end else if (out_en) begin
            o_sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_fft_mdc_stage.sv
// tb_fft_mdc_stage: drives a DELAY=4 and a DELAY=1 stage with identical stimulus.
// A formula-level model of each stage's output pairs feeds a scoreboard queue per instance.
module tb_fft_mdc_stage;

    localparam int NI   = 11;
    localparam int NC   = 11;
    localparam int NF   = 9;
    localparam int NO   = 12;
    localparam int OMAX = (1 << (NO - 1)) - 1;
    localparam int OMIN = -(1 << (NO - 1));
    localparam int RND  = 1 << (NF - 1);

    typedef struct {
        int       ure;
        int       uim;
        int       lre;
        int       lim;
        bit [1:0] uc;
        bit [1:0] lc;
    } samp_t;

    typedef struct {
        logic [2*NO-1:0] up;
        logic [2*NO-1:0] dn;
        logic            sat;
        int              cc;
    } exp_t;

    logic clk;
    logic rst;
    logic i_valid;
    logic [2*NI-1:0] i_up;
    logic [2*NI-1:0] i_down;

    logic [2:0]      coeff_addr4;
    logic [2*NC-1:0] coeff_in4;
    logic            o_valid4;
    logic [2*NO-1:0] o_up4;
    logic [2*NO-1:0] o_down4;
    logic            o_sat4;

    logic [0:0]      coeff_addr1;
    logic [2*NC-1:0] coeff_in1;
    logic            o_valid1;
    logic [2*NO-1:0] o_up1;
    logic [2*NO-1:0] o_down1;
    logic            o_sat1;

    logic [2*NC-1:0] tab4 [8];
    logic [2*NC-1:0] tab1 [2];

    samp_t hist [2][512];
    exp_t  q4 [$];
    exp_t  q1 [$];
    exp_t  last4;
    exp_t  last1;
    bit    expv4;
    bit    expv1;
    int    n_acc;
    int    n_cmp;
    int    n_bad;

`ifdef FFT_MDC_STAGE_SATCNT_EN
    logic [15:0] sc4;
    logic [15:0] sc1;
    int          scm4;
    int          scm1;
`endif

    assign coeff_in4 = tab4[coeff_addr4];
    assign coeff_in1 = tab1[coeff_addr1];

    fft_mdc_stage #(
        .NBITS_IN(NI), .NBITS_COEFF(NC), .NBF_COEFF(NF), .NBITS_OUT(NO), .DELAY(4)
    ) dut4 (
        .clk(clk),
        .rst(rst),
        .i_valid(i_valid),
        .i_up(i_up),
        .i_down(i_down),
        .coeff_addr(coeff_addr4),
        .coeff_in(coeff_in4),
        .o_valid(o_valid4),
        .o_up(o_up4),
        .o_down(o_down4),
        .o_sat(o_sat4)
`ifdef FFT_MDC_STAGE_SATCNT_EN
        ,
        .o_sat_count(sc4)
`endif
    );

    fft_mdc_stage #(
        .NBITS_IN(NI), .NBITS_COEFF(NC), .NBF_COEFF(NF), .NBITS_OUT(NO), .DELAY(1)
    ) dut1 (
        .clk(clk),
        .rst(rst),
        .i_valid(i_valid),
        .i_up(i_up),
        .i_down(i_down),
        .coeff_addr(coeff_addr1),
        .coeff_in(coeff_in1),
        .o_valid(o_valid1),
        .o_up(o_up1),
        .o_down(o_down1),
        .o_sat(o_sat1)
`ifdef FFT_MDC_STAGE_SATCNT_EN
        ,
        .o_sat_count(sc1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_cmp++;
        assert (obs === expd) else begin
            n_bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expd);
        end
    endtask

    function automatic int satv(input int v, output bit c);
        c = (v > OMAX) || (v < OMIN);
        if (v > OMAX) return OMAX;
        if (v < OMIN) return OMIN;
        return v;
    endfunction

    function automatic logic [2*NO-1:0] pk(input int re, input int im);
        return {NO'(re), NO'(im)};
    endfunction

    // Computes U[n], L[n] for the accepted sample and pushes the pair leaving the commutator, if any.
    task automatic modelPush(input int inst, input int ur, input int ui, input int dr, input int di);
        int d, cr, ci, br, bi, m, k;
        bit c0, c1, c2, c3;
        logic [2*NC-1:0] c;
        samp_t s, x, y;
        exp_t e;
        d  = (inst == 0) ? 4 : 1;
        c  = (inst == 0) ? tab4[n_acc % 8] : tab1[n_acc % 2];
        cr = int'($signed(c[2*NC-1:NC]));
        ci = int'($signed(c[NC-1:0]));
        br = ur - dr;
        bi = ui - di;
        s.ure = satv(ur + dr, c0);
        s.uim = satv(ui + di, c1);
        s.lre = satv((br * cr - bi * ci + RND) >>> NF, c2);
        s.lim = satv((br * ci + bi * cr + RND) >>> NF, c3);
        s.uc  = {c0, c1};
        s.lc  = {c2, c3};
        hist[inst][n_acc] = s;
        m = n_acc - 2;
        if (m >= d) begin
            k = m % (2 * d);
            if (k >= d) begin
                x = hist[inst][m - d];
                y = hist[inst][m];
                e.up = pk(x.ure, x.uim);
                e.dn = pk(y.ure, y.uim);
                e.cc = $countones({x.uc, y.uc});
            end else begin
                x = hist[inst][m - 2 * d];
                y = hist[inst][m - d];
                e.up = pk(x.lre, x.lim);
                e.dn = pk(y.lre, y.lim);
                e.cc = $countones({x.lc, y.lc});
            end
            e.sat = (e.cc != 0);
            if (inst == 0) begin
                q4.push_back(e);
                expv4 = 1'b1;
            end else begin
                q1.push_back(e);
                expv1 = 1'b1;
            end
        end
    endtask

    task automatic checkOutput();
        chk("o_valid_d4", 32'(o_valid4), 32'(expv4));
        chk("o_valid_d1", 32'(o_valid1), 32'(expv1));
        if (q4.size() != 0) begin
            last4 = q4.pop_front();
`ifdef FFT_MDC_STAGE_SATCNT_EN
            scm4 = (scm4 + last4.cc > 65535) ? 65535 : scm4 + last4.cc;
`endif
        end
        if (q1.size() != 0) begin
            last1 = q1.pop_front();
`ifdef FFT_MDC_STAGE_SATCNT_EN
            scm1 = (scm1 + last1.cc > 65535) ? 65535 : scm1 + last1.cc;
`endif
        end
        chk("o_up_d4", 32'(o_up4), 32'(last4.up));
        chk("o_down_d4", 32'(o_down4), 32'(last4.dn));
        chk("o_sat_d4", 32'(o_sat4), 32'(last4.sat));
        chk("o_up_d1", 32'(o_up1), 32'(last1.up));
        chk("o_down_d1", 32'(o_down1), 32'(last1.dn));
        chk("o_sat_d1", 32'(o_sat1), 32'(last1.sat));
        if (n_acc > 0) begin
            chk("coeff_addr_d4", 32'(coeff_addr4), 32'((n_acc - 1) % 8));
            chk("coeff_addr_d1", 32'(coeff_addr1), 32'((n_acc - 1) % 2));
        end
`ifdef FFT_MDC_STAGE_SATCNT_EN
        chk("o_sat_count_d4", 32'(sc4), 32'(scm4));
        chk("o_sat_count_d1", 32'(sc1), 32'(scm1));
`endif
    endtask

    task automatic applyStimulus(input bit v, input int ur, input int ui, input int dr, input int di);
        i_valid = v;
        i_up    = {NI'(ur), NI'(ui)};
        i_down  = {NI'(dr), NI'(di)};
        expv4   = 1'b0;
        expv1   = 1'b0;
        if (v) begin
            modelPush(0, ur, ui, dr, di);
            modelPush(1, ur, ui, dr, di);
            n_acc++;
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Reset with i_valid held high: the presented sample must be dropped.
    task automatic doReset();
        rst     = 1'b1;
        i_valid = 1'b1;
        i_up    = {NI'(77), NI'(-5)};
        i_down  = {NI'(-33), NI'(9)};
        @(posedge clk);
        #1;
        rst     = 1'b0;
        i_valid = 1'b0;
        n_acc   = 0;
        expv4   = 1'b0;
        expv1   = 1'b0;
        q4.delete();
        q1.delete();
        last4   = '{up: '0, dn: '0, sat: 1'b0, cc: 0};
        last1   = '{up: '0, dn: '0, sat: 1'b0, cc: 0};
`ifdef FFT_MDC_STAGE_SATCNT_EN
        scm4    = 0;
        scm1    = 0;
`endif
        checkOutput();
    endtask

    task automatic setCoeff(input int re, input int im);
        for (int k = 0; k < 8; k++) tab4[k] = {NC'(re), NC'(im)};
        for (int k = 0; k < 2; k++) tab1[k] = {NC'(re), NC'(im)};
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        n_acc   = 0;
        rst     = 1'b1;
        i_valid = 1'b0;
        i_up    = '0;
        i_down  = '0;
        setCoeff(512, 0);
        @(posedge clk);
        #1;

        $display("[TB] identity twiddle, continuous input");
        doReset();
        setCoeff(512, 0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 100, 0, 20, 0);

        $display("[TB] identity twiddle, input with gaps");
        doReset();
        for (int i = 0; i < 40; i++) applyStimulus(1'(~i[0]), (i % 2 == 0) ? 100 : 555, 0, (i % 2 == 0) ? 20 : -321, 3);

        $display("[TB] multiply by j");
        doReset();
        setCoeff(0, 512);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 0, 0, -30, 10);

        $display("[TB] rounding");
        doReset();
        setCoeff(256, 0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 3, 0, 0, 0);

        $display("[TB] saturation");
        doReset();
        setCoeff(1023, 0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1023, 0, -1024, 0);

        $display("[TB] ramp with reset at accept 10");
        doReset();
        setCoeff(512, 0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, i, 0, 0, 0);
        doReset();
        for (int i = 0; i < 14; i++) applyStimulus(1'b1, i, 0, 0, 0);

        $display("[TB] address-dependent twiddles, random data and gaps");
        doReset();
        for (int k = 0; k < 8; k++) tab4[k] = {NC'(512 - 40 * k), NC'(30 * k - 100)};
        tab1[0] = {NC'(300), NC'(-200)};
        tab1[1] = {NC'(-450), NC'(150)};
        for (int i = 0; i < 48; i++) begin
            applyStimulus(1'($urandom_range(3) != 0),
                          int'($urandom_range(2047)) - 1024, int'($urandom_range(2047)) - 1024,
                          int'($urandom_range(2047)) - 1024, int'($urandom_range(2047)) - 1024);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_mdc_stage.md
Name: fft_mdc_stage

Overview:
- Parametrised radix-2 stage for the 2-lane (up/down) multipath delay-commutator FFT datapath. Generalises the fixed BF + twiddle multiply + commutator + saturation chain into one reusable stage.
- Chain: registered butterfly, twiddle multiply on the down lane, round/saturate to the output width, delay commutator of programmable depth.
- Valid-gated: the pipeline advances only on accepted samples, so input gaps are tolerated. Stages cascade with DELAY halving per stage.

Parameters:
- NBITS_IN, 11: width of each real/imag input component.
- NBITS_COEFF, 11: width of each twiddle component (signed).
- NBF_COEFF, 9: fractional bits of the twiddle; 1.0 = 512.
- NBITS_OUT, 12: width of each output component.
- DELAY, 16: commutator depth D; power of 2, >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_valid  in  1  input pair accepted this cycle
- i_up  in  2*NBITS_IN  {re,im}, re in upper half, two's complement
- i_down  in  2*NBITS_IN  {re,im}
- coeff_addr  out  log2(2*DELAY)  twiddle index for external coeff memory
- coeff_in  in  2*NBITS_COEFF  {re,im} twiddle, combinational read of coeff_addr
- o_valid  out  1  output pair valid
- o_up  out  2*NBITS_OUT  {re,im}
- o_down  out  2*NBITS_OUT  {re,im}
- o_sat  out  1  at least one component of this output pair clipped

Behaviour:
- Reset (synchronous): all counters, fill state, o_valid, o_sat = 0; o_up and o_down = 0. Delay-line contents are don't-care because the fill gating hides them.
- Reset mid-operation: the next accepted sample is treated as sample index 0 and the full fill sequence restarts.
- Accepted-sample index n counts from 0 after reset. All pipeline registers update only when i_valid=1.
- S1, butterfly (registered): A = up + down, B = up - down. Per component, width NBITS_IN+1, no overflow.
- S2, twiddle (registered):
  - Down lane: P = B * coeff_in as a full complex product (re = Br*Cr - Bi*Ci; im = Br*Ci + Bi*Cr).
  - Add 2^(NBF_COEFF-1), arithmetic shift right by NBF_COEFF, saturate to NBITS_OUT (range -2^(NBITS_OUT-1) .. 2^(NBITS_OUT-1)-1).
  - Up lane: A is sign-extended and saturated to NBITS_OUT, no shift.
  - A clip flag per lane travels with the data through the commutator.
- coeff_addr = (n-1) mod 2*DELAY, taken from the sample currently held in S1. It is driven combinationally while that sample advances into S2.
- Commutator on the S2 stream, index m = n-2. Phase s = (m / D) mod 2.
  - The lower lane L is delayed by D.
  - Switch: s=0 straight, s=1 crossed.
  - The switch's upper output is delayed by D.
  - Resulting output pairs:
    - m mod 2D in [D,2D): (U[m-D], U[m])
    - m mod 2D in [0,D) with m >= 2D: (L[m-2D], L[m-D])
- o_valid is registered: 1 in the cycle after accept n iff n >= DELAY+2. It is 0 in any cycle following i_valid=0.
- o_up, o_down, o_sat update only together with o_valid=1 and hold otherwise.
- o_sat = OR of the clip flags of the two samples forming the output pair.
- Counters wrap modulo 2*DELAY with no discontinuity. Latency in accepted samples is constant across gaps.
- DELAY=1: the commutator swaps every sample; the same rules apply.

Optional Feature:
- Macro: FFT_MDC_STAGE_SATCNT_EN.
- Defined: adds output port o_sat_count (16 bits).
  - Counts clipped components, up to 4 per output pair, on o_valid cycles.
  - Saturates at 0xFFFF; cleared by rst.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- DELAY=4, coeff_in=(512,0), i_valid held 1, up=(100,0), down=(20,0):
  - o_valid rises after accept 6.
  - Then alternating 4 cycles o_up=o_down=(120,0) and 4 cycles o_up=o_down=(80,0).
  - o_sat=0.
- Same stimulus with i_valid toggling 1,0,1,0: o_valid only follows accepted cycles, and the output sequence is identical to the continuous case, just stretched in time.
- coeff_in=(0,512), i.e. multiply by j; up=(0,0), down=(-30,10): B=(30,-10), so L-pairs = (10,30). Also check rounding with coeff_in=(256,0) and B=(3,0): (3*256 + 256) >> 9 = 2.
- coeff_in=(1023,0), up=(1023,0), down=(-1024,0): B=2047, product clips to 2047; o_sat=1 on the L-pairs only. With FFT_MDC_STAGE_SATCNT_EN defined, o_sat_count increments by 2 per L-pair.
- Ramp input, DELAY=4: assert rst for 1 cycle at accept 10. All outputs read 0; o_valid stays 0 until 6 accepts after reset. coeff_addr restarts at 0 with the first sample in S1.
- DELAY=1, ramp up=k, down=0, coeff=(512,0): output pairs alternate (U[m-1],U[m]) and (L[m-2],L[m-1]) every cycle; coeff_addr toggles 0/1.
